// File: rtl/test_campaign_runner.sv
// rtl/test_campaign_runner.sv - sequential test campaign runner with per-test reset, settle, request and timeout
// Optional: define TEST_RUNNER_STOP_ON_FAIL_EN to end the campaign at the first failing test.
module test_campaign_runner #(
  parameter int NUM_TESTS    = 4,
  parameter int RESET_CYCLES = 6,
  parameter int START_DELAY  = 92,
  parameter int MIN_WAIT     = 4,
  parameter int TIMEOUT      = 100000,
  parameter int CNT_W        = 32,
  localparam int IDX_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 dut_reset,
  output logic [NUM_TESTS-1:0] test_req,
  input  logic [NUM_TESTS-1:0] test_busy,
  input  logic [NUM_TESTS-1:0] test_return,
  output logic [IDX_W-1:0]     cur_index,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_SETTLE, S_RUN, S_CHECK, S_DONE} state_t;

  // One shared counter times RST, SETTLE and RUN; it is zero on entry to each of them.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] WAIT_MIN    = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_TESTS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       cur_index_q, cur_index_d;
  logic [NUM_TESTS-1:0]   fail_mask_q, fail_mask_d;
  logic [NUM_TESTS-1:0]   timeout_mask_q, timeout_mask_d;
  logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
  logic                   timed_out_q, timed_out_d;

  logic busy_cur, ret_cur, rst_last, settle_last, run_complete, run_timeout, test_failed, last_test;

  assign busy_cur     = test_busy[cur_index_q];
  assign ret_cur      = test_return[cur_index_q];
  assign rst_last     = (cnt_q == RST_LAST);
  assign settle_last  = (cnt_q == SETTLE_LAST);
  assign run_complete = (cnt_q >= WAIT_MIN) && !busy_cur;
  assign run_timeout  = (cnt_q == WAIT_LAST);
  assign test_failed  = timed_out_q | ~ret_cur;
  assign last_test    = (cur_index_q == IDX_LAST);

  // State and datapath registers; reset drops everything back to idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cur_index_q    <= '0;
      fail_mask_q    <= '0;
      timeout_mask_q <= '0;
      cycle_count_q  <= '0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cur_index_q    <= cur_index_d;
      fail_mask_q    <= fail_mask_d;
      timeout_mask_q <= timeout_mask_d;
      cycle_count_q  <= cycle_count_d;
      timed_out_q    <= timed_out_d;
    end
  end

  // Next-state sequencing through reset, settle, run and check for each test.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RST;
      S_RST:          if (rst_last) state_d = (START_DELAY == 0) ? S_RUN : S_SETTLE;
      S_SETTLE:       if (settle_last) state_d = S_RUN;
      S_RUN:          if (run_complete || run_timeout) state_d = S_CHECK;
      S_CHECK: begin
`ifdef TEST_RUNNER_STOP_ON_FAIL_EN
        state_d = (last_test || test_failed) ? S_DONE : S_RST;
`else
        state_d = last_test ? S_DONE : S_RST;
`endif
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Counters, result masks and the timed-out flag carried from RUN into CHECK.
  always_comb begin
    cnt_d          = cnt_q;
    cur_index_d    = cur_index_q;
    fail_mask_d    = fail_mask_q;
    timeout_mask_d = timeout_mask_q;
    cycle_count_d  = cycle_count_q;
    timed_out_d    = timed_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d          = '0;
          cur_index_d    = '0;
          fail_mask_d    = '0;
          timeout_mask_d = '0;
          cycle_count_d  = '0;
          timed_out_d    = 1'b0;
        end
      end
      S_RST:    cnt_d = rst_last ? '0 : cnt_q + CNT_W'(1);
      S_SETTLE: cnt_d = settle_last ? '0 : cnt_q + CNT_W'(1);
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (run_complete || run_timeout) begin
          cnt_d       = '0;
          timed_out_d = ~run_complete;
        end
      end
      S_CHECK: begin
        cnt_d                       = '0;
        fail_mask_d[cur_index_q]    = test_failed;
        timeout_mask_d[cur_index_q] = timed_out_q;
        if (state_d == S_RST) cur_index_d = cur_index_q + IDX_W'(1);
      end
      default: cnt_d = '0;
    endcase
    // Campaign cycle counter runs only while a campaign is active and sticks at all-ones.
    if (state_q != S_IDLE && state_q != S_DONE && cycle_count_q != {CNT_W{1'b1}})
      cycle_count_d = cycle_count_q + CNT_W'(1);
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    test_req = '0;
    if (state_q == S_RUN) test_req[cur_index_q] = 1'b1;
    dut_reset = (state_q == S_IDLE) || (state_q == S_RST) || (state_q == S_DONE);
    done      = (state_q == S_DONE);
    pass      = (state_q == S_DONE) && (fail_mask_q == '0);
  end

  assign cur_index    = cur_index_q;
  assign fail_mask    = fail_mask_q;
  assign timeout_mask = timeout_mask_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_test_campaign_runner.sv
// tb/tb_test_campaign_runner.sv - self-checking bench for test_campaign_runner
module tb_test_campaign_runner;

  localparam int NT = 4;
  localparam int RC = 6;
  localparam int SD = 92;
  localparam int MW = 4;
  localparam int TO = 50;
  localparam int CW = 9;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TEST_RUNNER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          dut_reset;
  logic [NT-1:0] test_req;
  logic [NT-1:0] test_busy = '0;
  logic [NT-1:0] test_return = '0;
  logic [1:0]    cur_index;
  logic          done, pass;
  logic [NT-1:0] fail_mask, timeout_mask;
  logic [CW-1:0] cycle_count;

  test_campaign_runner #(
    .NUM_TESTS(NT), .RESET_CYCLES(RC), .START_DELAY(SD),
    .MIN_WAIT(MW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset),
    .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
    .cur_index(cur_index), .done(done), .pass(pass), .fail_mask(fail_mask),
    .timeout_mask(timeout_mask), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural test modules: busy pattern counted from the request rise.
  int cfg_lo[NT], cfg_len[NT];
  bit cfg_ret[NT], cfg_hang[NT];
  int kc[NT];

  always @(negedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (test_req[i]) begin
        test_busy[i] = cfg_hang[i] || (kc[i] >= cfg_lo[i] && kc[i] < cfg_lo[i] + cfg_len[i]);
        kc[i]++;
      end else begin
        kc[i] = 0;
        test_busy[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Request monitor: one-hot check, high-time per channel and settle gap before each rise.
  int req_len[NT], settle_obs[NT];
  int ll = 0;
  logic [NT-1:0] prev_req = '0;

  always @(negedge clk) begin
    if (reset) begin
      if ($countones(test_req) > 1) chk("req_onehot", test_req, 0);
      for (int i = 0; i < NT; i++) begin
        if (test_req[i]) req_len[i]++;
        if (test_req[i] && !prev_req[i]) settle_obs[i] = ll;
      end
      if (dut_reset || test_req != 0) ll = 0;
      else ll++;
    end
    prev_req = test_req;
  end

  // Reference: scan the RUN window wait by wait following the completion and timeout rules.
  function automatic int run_len(input int lo, input int len, input bit hang, output bit to);
    for (int w = 0; w < TO; w++) begin
      bit b;
      b = hang || (w >= lo && w < lo + len);
      if (w >= MW && !b) begin
        to = 1'b0;
        return w + 1;
      end
    end
    to = 1'b1;
    return TO;
  endfunction

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] len;
    logic [3:0]  ret;
    logic [3:0]  hang;
    logic [3:0]  ef;
    logic [3:0]  et;
    logic [1:0]  eidx;
    logic        ep;
  } vec_t;

  logic [3:0] m_fm, m_tm;
  logic [1:0] m_idx;

  task automatic run_campaign(input vec_t v, input string tag);
    int exp_n, cyc;
    int exp_rl[NT];
    bit to, fl;
    exp_n = 0; m_fm = '0; m_tm = '0; m_idx = '0;
    for (int i = 0; i < NT; i++) begin
      cfg_lo[i]   = int'(v.lo[8*i +: 8]);
      cfg_len[i]  = int'(v.len[8*i +: 8]);
      cfg_ret[i]  = v.ret[i];
      cfg_hang[i] = v.hang[i];
      test_return[i] = v.ret[i];
      exp_rl[i] = 0; req_len[i] = 0; settle_obs[i] = 0;
    end
    for (int i = 0; i < NT; i++) begin
      exp_rl[i] = run_len(cfg_lo[i], cfg_len[i], cfg_hang[i], to);
      exp_n += RC + SD + exp_rl[i] + 1;
      fl = to | ~cfg_ret[i];
      m_fm[i] = fl; m_tm[i] = to; m_idx = 2'(i);
      if (STOP && fl) break;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 40);
      if (done) break;
    end
    start = 1'b0;
    chk({tag, " done_reached"}, done, 1);
    chk({tag, " campaign_cycles"}, cyc, exp_n);
    chk({tag, " fail_mask"}, fail_mask, m_fm);
    chk({tag, " timeout_mask"}, timeout_mask, m_tm);
    chk({tag, " pass"}, pass, m_fm == 0);
    chk({tag, " cur_index"}, cur_index, m_idx);
    chk({tag, " cycle_count"}, cycle_count, (exp_n > CMAX) ? CMAX : exp_n);
    for (int i = 0; i < NT; i++) begin
      chk($sformatf("%s req_len[%0d]", tag, i), req_len[i], exp_rl[i]);
      chk($sformatf("%s settle[%0d]", tag, i), settle_obs[i], (exp_rl[i] != 0) ? SD : 0);
    end
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    int n, cc;
    tbl[0] = '{lo:32'h0, len:32'h14141414, ret:4'hF, hang:4'h0, ef:4'h0, et:4'h0, eidx:2'd3, ep:1'b1};
    tbl[1] = '{lo:32'h0, len:32'h14141414, ret:4'b1011, hang:4'h0, ef:4'b0100, et:4'h0,
               eidx:(STOP ? 2'd2 : 2'd3), ep:1'b0};
    tbl[2] = '{lo:32'h0, len:32'h14141414, ret:4'hF, hang:4'b0010, ef:4'b0010, et:4'b0010,
               eidx:(STOP ? 2'd1 : 2'd3), ep:1'b0};
    tbl[3] = '{lo:32'h02020202, len:32'h0A0A0A0A, ret:4'hF, hang:4'h0, ef:4'h0, et:4'h0, eidx:2'd3, ep:1'b1};
    tbl[4] = '{lo:32'h0, len:32'h14141414, ret:4'b1101, hang:4'b1000,
               ef:(STOP ? 4'b0010 : 4'b1010), et:(STOP ? 4'b0000 : 4'b1000),
               eidx:(STOP ? 2'd1 : 2'd3), ep:1'b0};
    tbl[5] = '{lo:32'h0, len:32'h14143231, ret:4'hF, hang:4'h0, ef:4'b0010, et:4'b0010,
               eidx:(STOP ? 2'd1 : 2'd3), ep:1'b0};

    repeat (3) @(negedge clk);
    chk("rst dut_reset", dut_reset, 1);
    chk("rst test_req", test_req, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst cur_index", cur_index, 0);
    chk("rst masks", {fail_mask, timeout_mask}, 0);
    chk("rst cycle_count", cycle_count, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle hold", {done, dut_reset, test_req}, 5'b01_0000);

    for (int t = 0; t < 6; t++) begin
      run_campaign(tbl[t], $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d const fail_mask", t), fail_mask, tbl[t].ef);
      chk($sformatf("tbl%0d const timeout_mask", t), timeout_mask, tbl[t].et);
      chk($sformatf("tbl%0d const cur_index", t), cur_index, tbl[t].eidx);
      chk($sformatf("tbl%0d const pass", t), pass, tbl[t].ep);
      if (t == 0) begin
        cc = int'(cycle_count);
        repeat (5) @(negedge clk);
        chk("done held", {done, dut_reset}, 2'b11);
        chk("cycle_count frozen", cycle_count, cc);
      end
    end

    // Reset pulled low in the middle of test 1, then a clean rerun.
    for (int i = 0; i < NT; i++) begin
      cfg_lo[i] = 0; cfg_len[i] = 20; cfg_ret[i] = 1'b1; cfg_hang[i] = 1'b0; test_return[i] = 1'b1;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!test_req[1] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid reached req1", test_req[1], 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid rst dut_reset", dut_reset, 1);
    chk("mid rst test_req", test_req, 0);
    chk("mid rst cur_index", cur_index, 0);
    chk("mid rst masks", {fail_mask, timeout_mask}, 0);
    chk("mid rst cycle_count", cycle_count, 0);
    chk("mid rst done_pass", {done, pass}, 0);
    @(negedge clk) reset = 1'b1;
    run_campaign(tbl[0], "rerun");

    // Randomised campaigns against the reference model.
    for (int r = 0; r < 8; r++) begin
      v = '0;
      for (int i = 0; i < NT; i++) begin
        v.lo[8*i +: 8]  = 8'($urandom_range(0, 6));
        v.len[8*i +: 8] = 8'($urandom_range(0, 55));
        v.ret[i]        = ($urandom_range(0, 3) != 0);
        v.hang[i]       = ($urandom_range(0, 7) == 0);
      end
      run_campaign(v, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
